// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the frame timing controller.
// Holds the sequencer state enum, pattern codes and the auto-cycle helper.
package frame_gen_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int PAT_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VFRONT,
      ST_LINE,
      ST_HBLANK,
      ST_VBACK,
      ST_FBLANK
   } frame_state_e;

   localparam logic [PAT_W-1:0] PAT_BLACK = 3'b000;
   localparam logic [PAT_W-1:0] PAT_WHITE = 3'b001;
   localparam logic [PAT_W-1:0] PAT_GRAD  = 3'b010;
   localparam logic [PAT_W-1:0] PAT_CHECK = 3'b011;
   localparam logic [PAT_W-1:0] PAT_AUTO  = 3'b100;
   localparam logic [PAT_W-1:0] PAT_LOGO  = 3'b111;

   // Auto-cycle order: BLACK, WHITE, GRAD, CHECK, LOGO, then wrap.
   function automatic logic [PAT_W-1:0] next_auto_pat(
      input logic [PAT_W-1:0] cur
   );
      logic [PAT_W-1:0] nxt;
      nxt = PAT_BLACK;
      unique case (cur)
         PAT_BLACK: nxt = PAT_WHITE;
         PAT_WHITE: nxt = PAT_GRAD;
         PAT_GRAD:  nxt = PAT_CHECK;
         PAT_CHECK: nxt = PAT_LOGO;
         default:   nxt = PAT_BLACK;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/frame_timing_ctrl_if.sv
// Control/timing bundle between a frame source and the timing controller.
// master: controller side (drives timing); slave: consumer side (drives enable/sel_in).
interface frame_timing_ctrl_if;
   import frame_gen_pkg::*;

   logic             enable;
   logic [PAT_W-1:0] sel_in;
   logic             fval;
   logic             lval;
   logic             dval;
   logic             fval_posedge;
   logic             lval_negedge;
   logic [PAT_W-1:0] sel_out;
   logic             busy;
   logic             frame_done;

   modport master (
      input  enable, sel_in,
      output fval, lval, dval, fval_posedge, lval_negedge,
      output sel_out, busy, frame_done
   );

   modport slave (
      output enable, sel_in,
      input  fval, lval, dval, fval_posedge, lval_negedge,
      input  sel_out, busy, frame_done
   );

endinterface

// File: rtl/frame_cycle_counter.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
// Ports: clk, rst, load_i, load_val_i, dec_i, tc_o (count == 0).
module frame_cycle_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/frame_timing_ctrl.sv
// Frame sequencer generating registered FVAL/LVAL/DVAL timing and strobes.
// Ports: clk, rst (sync, active-high), tim_if (master: enable/sel_in in,
// fval/lval/dval/fval_posedge/lval_negedge/sel_out/busy/frame_done out).
// Optional macro FRAME_PATTERN_CYCLE_EN enables sel_in=100 auto-cycle mode.
module frame_timing_ctrl
   import frame_gen_pkg::*;
#(
   parameter int DVAL_HIGH = 640,
   parameter int ROW_COUNT = 480,
   parameter int H_BLANK   = 16,
   parameter int V_FRONT   = 8,
   parameter int V_BACK    = 8,
   parameter int F_BLANK   = 32,
   parameter int CNT_W     = CNT_W_DEF
) (
   input logic                clk,
   input logic                rst,
   frame_timing_ctrl_if.master tim_if
);

   if (DVAL_HIGH < 1 || ROW_COUNT < 1 || H_BLANK < 1 ||
       V_FRONT < 1 || V_BACK < 1 || F_BLANK < 1 ||
       64'(DVAL_HIGH) >= (64'd1 << CNT_W) ||
       64'(ROW_COUNT) >= (64'd1 << CNT_W)) begin : g_param_err
      $error("frame_timing_ctrl: illegal timing parameters");
   end

   // Counters run down from duration-1 to zero.
   localparam logic [CNT_W-1:0] LD_VF = CNT_W'(V_FRONT - 1);
   localparam logic [CNT_W-1:0] LD_DH = CNT_W'(DVAL_HIGH - 1);
   localparam logic [CNT_W-1:0] LD_HB = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] LD_VB = CNT_W'(V_BACK - 1);
   localparam logic [CNT_W-1:0] LD_FB = CNT_W'(F_BLANK - 1);
   localparam logic [CNT_W-1:0] LD_RC = CNT_W'(ROW_COUNT - 1);

   frame_state_e state_q, state_d;

   logic             pix_ld, pix_tc;
   logic [CNT_W-1:0] pix_val;
   logic             ln_ld, ln_dec, ln_tc;

   logic             fval_q, fval_d;
   logic             lval_q, lval_d;
   logic             fpos_q, fpos_d;
   logic             lneg_q, lneg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [PAT_W-1:0] sel_q, sel_d;

   frame_cycle_counter #(.W(CNT_W)) u_pix_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (pix_ld),
      .load_val_i (pix_val),
      .dec_i      (1'b1),
      .tc_o       (pix_tc)
   );

   // Remaining lines after the current one; decremented on HBLANK entry.
   frame_cycle_counter #(.W(CNT_W)) u_line_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ln_ld),
      .load_val_i (LD_RC),
      .dec_i      (ln_dec),
      .tc_o       (ln_tc)
   );

   always_comb begin
      state_d = state_q;
      pix_ld  = 1'b0;
      pix_val = '0;
      ln_ld   = 1'b0;
      ln_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tim_if.enable) begin
               state_d = ST_VFRONT;
               pix_ld  = 1'b1;
               pix_val = LD_VF;
               ln_ld   = 1'b1;
            end
         end
         ST_VFRONT: begin
            if (pix_tc) begin
               state_d = ST_LINE;
               pix_ld  = 1'b1;
               pix_val = LD_DH;
            end
         end
         ST_LINE: begin
            if (pix_tc) begin
               pix_ld = 1'b1;
               if (ln_tc) begin
                  state_d = ST_VBACK;
                  pix_val = LD_VB;
               end else begin
                  state_d = ST_HBLANK;
                  pix_val = LD_HB;
                  ln_dec  = 1'b1;
               end
            end
         end
         ST_HBLANK: begin
            if (pix_tc) begin
               state_d = ST_LINE;
               pix_ld  = 1'b1;
               pix_val = LD_DH;
            end
         end
         ST_VBACK: begin
            if (pix_tc) begin
               state_d = ST_FBLANK;
               pix_ld  = 1'b1;
               pix_val = LD_FB;
            end
         end
         ST_FBLANK: begin
            if (pix_tc) begin
               if (tim_if.enable) begin
                  state_d = ST_VFRONT;
                  pix_ld  = 1'b1;
                  pix_val = LD_VF;
                  ln_ld   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they
   // line up with the state register.
   always_comb begin
      fval_d = (state_d != ST_IDLE) && (state_d != ST_FBLANK);
      lval_d = (state_d == ST_LINE);
      busy_d = (state_d != ST_IDLE);
      fpos_d = (state_d == ST_VFRONT) && (state_q != ST_VFRONT);
      lneg_d = (state_q == ST_LINE) &&
               ((state_d == ST_HBLANK) || (state_d == ST_VBACK));
      done_d = (state_q == ST_VBACK) && (state_d == ST_FBLANK);
   end

`ifdef FRAME_PATTERN_CYCLE_EN
   logic auto_q, auto_d;

   always_comb begin
      sel_d  = sel_q;
      auto_d = auto_q;
      if (fpos_d) begin
         if (tim_if.sel_in == PAT_AUTO) begin
            auto_d = 1'b1;
            sel_d  = auto_q ? next_auto_pat(sel_q) : PAT_BLACK;
         end else begin
            auto_d = 1'b0;
            sel_d  = tim_if.sel_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         auto_q <= 1'b0;
      end else begin
         auto_q <= auto_d;
      end
   end
`else
   always_comb begin
      sel_d = sel_q;
      if (fpos_d) begin
         sel_d = tim_if.sel_in;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fval_q  <= 1'b0;
         lval_q  <= 1'b0;
         fpos_q  <= 1'b0;
         lneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sel_q   <= PAT_BLACK;
      end else begin
         state_q <= state_d;
         fval_q  <= fval_d;
         lval_q  <= lval_d;
         fpos_q  <= fpos_d;
         lneg_q  <= lneg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sel_q   <= sel_d;
      end
   end

   assign tim_if.fval         = fval_q;
   assign tim_if.lval         = lval_q;
   assign tim_if.dval         = lval_q;
   assign tim_if.fval_posedge = fpos_q;
   assign tim_if.lval_negedge = lneg_q;
   assign tim_if.busy         = busy_q;
   assign tim_if.frame_done   = done_q;
   assign tim_if.sel_out      = sel_q;

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Self-checking bench for frame_timing_ctrl against a frame-position model.
// Honours FRAME_PATTERN_CYCLE_EN the same way the design does.
module tb_frame_timing_ctrl;

   localparam int DH  = 8;
   localparam int RC  = 4;
   localparam int HB  = 2;
   localparam int VF  = 3;
   localparam int VB  = 2;
   localparam int FB  = 4;
   localparam int ACT = VF + RC*DH + (RC-1)*HB + VB;
   localparam int PER = ACT + FB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_timing_ctrl_if bus();

   frame_timing_ctrl #(
      .DVAL_HIGH (DH),
      .ROW_COUNT (RC),
      .H_BLANK   (HB),
      .V_FRONT   (VF),
      .V_BACK    (VB),
      .F_BLANK   (FB),
      .CNT_W     (16)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .tim_if (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: pos = cycles since fval rise, -1 when idle.
   int         pos      = -1;
   logic [2:0] sel_exp  = 3'b000;
`ifdef FRAME_PATTERN_CYCLE_EN
   bit         auto_mode = 1'b0;
   int         auto_idx  = 0;
   logic [2:0] auto_seq [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
`endif

   int n_fval, n_lval, n_fpos, n_lneg, n_done;
   logic [2:0] sel_log [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_fval = 0; n_lval = 0; n_fpos = 0; n_lneg = 0; n_done = 0;
      sel_log.delete();
   endtask

   task automatic start_frame();
      pos = 0;
`ifdef FRAME_PATTERN_CYCLE_EN
      if (bus.sel_in == 3'b100) begin
         if (!auto_mode) begin
            auto_mode = 1'b1;
            auto_idx  = 0;
         end else begin
            auto_idx = (auto_idx + 1) % 5;
         end
         sel_exp = auto_seq[auto_idx];
      end else begin
         auto_mode = 1'b0;
         sel_exp   = bus.sel_in;
      end
`else
      sel_exp = bus.sel_in;
`endif
   endtask

   task automatic step();
      int q;
      logic e_f, e_l, e_ln;
      @(posedge clk);
      if (rst) begin
         pos     = -1;
         sel_exp = 3'b000;
`ifdef FRAME_PATTERN_CYCLE_EN
         auto_mode = 1'b0;
`endif
      end else if (pos < 0 || pos == PER-1) begin
         if (bus.enable) start_frame();
         else pos = -1;
      end else begin
         pos++;
      end
      #1;
      q    = pos - VF;
      e_f  = (pos >= 0) && (pos < ACT);
      e_l  = e_f && (q >= 0) && ((q % (DH+HB)) < DH);
      e_ln = e_f && (q >= 0) && ((q % (DH+HB)) == DH);
      chk("fval", bus.fval, e_f);
      chk("lval", bus.lval, e_l);
      chk("dval", bus.dval, e_l);
      chk("fval_posedge", bus.fval_posedge, pos == 0);
      chk("lval_negedge", bus.lval_negedge, e_ln);
      chk("frame_done", bus.frame_done, pos == ACT);
      chk("busy", bus.busy, pos >= 0);
      chk("sel_out", bus.sel_out, sel_exp);
      n_fval += int'(bus.fval === 1'b1);
      n_lval += int'(bus.lval === 1'b1);
      n_fpos += int'(bus.fval_posedge === 1'b1);
      n_lneg += int'(bus.lval_negedge === 1'b1);
      n_done += int'(bus.frame_done === 1'b1);
      if (bus.fval_posedge === 1'b1) sel_log.push_back(bus.sel_out);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.sel_in = 3'b000;
      rst = 1'b1;
      clr();
      step();
      step();
      rst = 1'b0;
      step();

      // single frame from a one-cycle enable
      bus.sel_in = 3'b010;
      bus.enable = 1'b1;
      clr();
      step();
      bus.enable = 1'b0;
      repeat (PER + 5) step();
      chk("single_fval_cycles", n_fval, ACT);
      chk("single_lval_cycles", n_lval, RC*DH);
      chk("single_fpos", n_fpos, 1);
      chk("single_lneg", n_lneg, RC);
      chk("single_done", n_done, 1);
      chk("single_idle_busy", bus.busy, 1'b0);

      // continuous frames, sel_in changed mid-frame
      bus.sel_in = 3'b010;
      bus.enable = 1'b1;
      clr();
      repeat (20) step();
      bus.sel_in = 3'b011;
      repeat (3*PER) step();
      chk("cont_fpos", n_fpos, 4);
      chk("cont_sel0", sel_log[0], 3'b010);
      chk("cont_sel1", sel_log[1], 3'b011);

      // stop request during line 2
      for (int i = 0; i < 2*PER && pos != VF + 2*(DH+HB) + 3; i++) step();
      chk("stop_reach_line2", pos, VF + 2*(DH+HB) + 3);
      bus.enable = 1'b0;
      clr();
      repeat (PER + 10) step();
      chk("stop_fpos", n_fpos, 0);
      chk("stop_lneg", n_lneg, 2);
      chk("stop_done", n_done, 1);

      // reset during line 1
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      for (int i = 0; i < 2*PER && pos != VF + (DH+HB) + 4; i++) step();
      chk("rst_reach_line1", pos, VF + (DH+HB) + 4);
      rst = 1'b1;
      clr();
      step();
      rst = 1'b0;
      chk("rst_lneg", n_lneg, 0);
      step();
      bus.enable = 1'b1;
      clr();
      step();
      bus.enable = 1'b0;
      repeat (PER + 3) step();
      chk("rst_refr_lneg", n_lneg, RC);
      chk("rst_refr_done", n_done, 1);

      // randomized traffic
      repeat (900) begin
         bus.enable = ($urandom_range(0, 3) != 0);
         bus.sel_in = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 249) == 0);
         step();
      end
      rst = 1'b0;

      // reserved code 100 for six frames
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.enable = 1'b1;
      bus.sel_in = 3'b100;
      clr();
      repeat (6*PER) step();
      bus.enable = 1'b0;
      chk("auto_frames", sel_log.size(), 6);
      if (sel_log.size() == 6) begin
`ifdef FRAME_PATTERN_CYCLE_EN
         chk("auto_f0", sel_log[0], 3'b000);
         chk("auto_f1", sel_log[1], 3'b001);
         chk("auto_f2", sel_log[2], 3'b010);
         chk("auto_f3", sel_log[3], 3'b011);
         chk("auto_f4", sel_log[4], 3'b111);
         chk("auto_f5", sel_log[5], 3'b000);
`else
         for (int i = 0; i < 6; i++) chk("verbatim_100", sel_log[i], 3'b100);
`endif
      end
      repeat (PER) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
